// File: rtl/pkt_rx_pkg.sv
// Shared types for the MAC receive-side packet reader: FSM states, descriptor layout
// and status bit positions.
package pkt_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rx_state_e;

    localparam int DEF_LEN_W   = 14;
    localparam int ST_OVERSIZE = 2;
    localparam int ST_FRAMING  = 1;
    localparam int ST_MAC_ERR  = 0;

    typedef struct packed {
        logic [DEF_LEN_W-1:0] len;
        logic [2:0]           status;
    } rx_desc_t;

    // Bytes carried by one beat: a full 8 unless it is the eop beat with a partial mod.
    function automatic logic [3:0] beat_bytes(input logic eop, input logic [2:0] mod);
        if (eop && (mod != 3'd0)) begin
            return {1'b0, mod};
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/pkt_rx_desc_fifo.sv
// First-word-fall-through synchronous FIFO for receive descriptors; a push and a pop in
// the same cycle are both honoured even when full.
module pkt_rx_desc_fifo
    import pkt_rx_pkg::*;
#(
    parameter type T     = rx_desc_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end

    // NOTE: use <= in clocked blocks so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q gates visibility, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pkt_rx_reader.sv
// Receive-side packet reader: pulls beats from the MAC, checks framing, measures length
// and queues one {len,status} descriptor per packet, with wrapping packet/error counters.
module pkt_rx_reader
    import pkt_rx_pkg::*;
#(
    parameter int LEN_W      = 14,
    parameter int DESC_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic             pkt_rx_val,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic             pkt_rx_err,
    output logic             desc_valid,
    input  logic             desc_ready,
    output logic [LEN_W-1:0] desc_len,
    output logic [2:0]       desc_status,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [2:0]       status;
    } desc_t;

    localparam logic [LEN_W:0] LEN_MAX = {1'b0, {LEN_W{1'b1}}};

    rx_state_e        state_q, state_d;
    logic             ren_q, ren_d;
    logic [LEN_W:0]   acc_q, acc_d;
    logic             first_q, first_d;
    logic             framing_q, framing_d;
    logic             pkt_inc_q, pkt_inc_d;
    logic [1:0]       err_inc_q, err_inc_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
    desc_t            fifo_wdata, fifo_rdata;
    logic [$clog2(DESC_DEPTH):0] unused_fifo_count;
    logic             unused_data;

    logic             is_close, pkt_framing, drop_close, drop_eop, stray;
    logic [LEN_W:0]   base, sum;

    function automatic desc_t make_desc(input logic [LEN_W:0] total, input logic framing,
                                        input logic mac_err);
        desc_t d;
        d.status              = '0;
        d.status[ST_OVERSIZE] = (total > LEN_MAX);
        d.status[ST_FRAMING]  = framing;
        d.status[ST_MAC_ERR]  = mac_err;
        d.len                 = (total > LEN_MAX) ? LEN_MAX[LEN_W-1:0] : total[LEN_W-1:0];
        return d;
    endfunction

    assign unused_data = ^pkt_rx_data;
    assign fifo_pop    = desc_valid && desc_ready;
    assign can_push    = !fifo_full || fifo_pop;
    assign desc_valid  = !fifo_empty;
    assign desc_len    = fifo_rdata.len;
    assign desc_status = fifo_rdata.status;
    assign pkt_rx_ren  = ren_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_cnt     = err_cnt_q;

    always_comb begin
        // NOTE: everything assigned here gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        ren_d      = ren_q;
        acc_d      = acc_q;
        first_d    = first_q;
        framing_d  = framing_q;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        drop_close = 1'b0;
        drop_eop   = 1'b0;
        stray      = 1'b0;

        // A sop after the first beat closes the running packet and restarts with this beat.
        is_close    = pkt_rx_sop && !first_q;
        pkt_framing = first_q ? !pkt_rx_sop : (framing_q && !is_close);
        base        = (first_q || is_close) ? '0 : acc_q;
        sum         = base + (LEN_W+1)'(beat_bytes(pkt_rx_eop, pkt_rx_mod));

        case (state_q)
            IDLE: begin
                stray = pkt_rx_val;
                if (pkt_rx_avail && !fifo_full) begin
                    state_d   = READ;
                    ren_d     = 1'b1;
                    first_d   = 1'b1;
                    framing_d = 1'b0;
                    acc_d     = '0;
                end
            end
            READ: begin
                if (pkt_rx_val) begin
                    first_d   = 1'b0;
                    framing_d = pkt_framing;
                    acc_d     = (sum > LEN_MAX) ? LEN_MAX + 1'b1 : sum;
                    if (is_close) begin
                        if (can_push && !pkt_rx_eop) begin
                            fifo_push  = 1'b1;
                            fifo_wdata = make_desc(acc_q, 1'b1, 1'b0);
                        end else begin
                            drop_close = 1'b1;
                        end
                    end
                    if (pkt_rx_eop) begin
                        state_d = DRAIN;
                        ren_d   = 1'b0;
                        if (can_push) begin
                            fifo_push  = 1'b1;
                            fifo_wdata = make_desc(sum, pkt_framing, pkt_rx_err);
                        end else begin
                            drop_eop = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                stray   = pkt_rx_val;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counters step one cycle after the descriptor write.
        pkt_inc_d = fifo_push;
        err_inc_d = {1'b0, drop_close} + {1'b0, drop_eop} + {1'b0, stray}
                  + {1'b0, fifo_push && (fifo_wdata.status != 3'b000)};
        pkt_cnt_d = pkt_cnt_q + CNT_W'(pkt_inc_q);
        err_cnt_d = err_cnt_q + CNT_W'(err_inc_q);
    end

    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q   <= IDLE;
            ren_q     <= 1'b0;
            acc_q     <= '0;
            first_q   <= 1'b0;
            framing_q <= 1'b0;
            pkt_inc_q <= 1'b0;
            err_inc_q <= '0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ren_q     <= ren_d;
            acc_q     <= acc_d;
            first_q   <= first_d;
            framing_q <= framing_d;
            pkt_inc_q <= pkt_inc_d;
            err_inc_q <= err_inc_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    pkt_rx_desc_fifo #(
        .T     (desc_t),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk       (clk_156m25),
        .rst_n     (reset_156m25_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Bench for pkt_rx_reader: a reactive MAC model feeds two instances (LEN_W=14 and LEN_W=6)
// and a scoreboard checks every popped descriptor plus the counters.
module tb_pkt_rx_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        avail, ren, ren_small, val, sop, eop, err, desc_ready;
    logic [63:0] data;
    logic [2:0]  mod;
    logic        desc_valid, desc_valid_s;
    logic [13:0] desc_len;
    logic [5:0]  desc_len_s;
    logic [2:0]  desc_status, desc_status_s;
    logic [31:0] pkt_cnt, err_cnt, pkt_cnt_s, err_cnt_s;

    always #5 clk = ~clk;

    pkt_rx_reader #(.LEN_W(14), .DESC_DEPTH(4), .CNT_W(32)) dut (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .pkt_rx_avail(avail), .pkt_rx_ren(ren),
        .pkt_rx_val(val), .pkt_rx_data(data), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
        .pkt_rx_mod(mod), .pkt_rx_err(err), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_len(desc_len), .desc_status(desc_status), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    pkt_rx_reader #(.LEN_W(6), .DESC_DEPTH(4), .CNT_W(32)) dut_small (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .pkt_rx_avail(avail), .pkt_rx_ren(ren_small),
        .pkt_rx_val(val), .pkt_rx_data(data), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
        .pkt_rx_mod(mod), .pkt_rx_err(err), .desc_valid(desc_valid_s), .desc_ready(desc_ready),
        .desc_len(desc_len_s), .desc_status(desc_status_s), .pkt_cnt(pkt_cnt_s),
        .err_cnt(err_cnt_s)
    );

    typedef struct { bit sop; bit eop; bit err; bit stray; bit [2:0] mod; } beat_t;
    typedef struct { int len; int st; int len_s; int st_s; } exp_t;
    typedef struct { int nbeats; int m; bit e; bit nosop; int len; int st; int len_s; int st_s; } vec_t;

    beat_t mac_q[$];
    exp_t  sb_q[$];
    vec_t  vecs[8];
    bit    ren_s, mac_stop;
    int    n_tests = 0, n_fail = 0;
    int    exp_pkt = 0, exp_err = 0, exp_err_s = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pending_pkt();
        foreach (mac_q[i]) if (mac_q[i].eop && !mac_q[i].stray) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: scoreboard pop at negedge, MAC beat drive just after posedge.
    task automatic tick();
        exp_t  e;
        beat_t b;
        @(negedge clk);
        ren_s = ren;
        if (desc_valid && desc_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL desc_unexpected: got len %0d status %0d, expected none",
                         desc_len, desc_status);
            end else begin
                e = sb_q.pop_front();
                check("desc_len", desc_len, e.len);
                check("desc_status", desc_status, e.st);
                check("desc_valid_small", desc_valid_s, 1);
                check("desc_len_small", desc_len_s, e.len_s);
                check("desc_status_small", desc_status_s, e.st_s);
            end
        end
        @(posedge clk);
        #1;
        data = {$urandom, $urandom};
        val = 1'b0; sop = 1'b0; eop = 1'b0; mod = 3'd0; err = 1'b0;
        if (!rst_n) begin
            mac_q.delete();
            mac_stop = 1'b0;
        end else begin
            if (!ren_s) mac_stop = 1'b0;
            if (mac_q.size() > 0 && (mac_q[0].stray || (ren_s && !mac_stop))) begin
                b = mac_q.pop_front();
                val = 1'b1; sop = b.sop; eop = b.eop; mod = b.mod; err = b.err;
                if (b.eop) mac_stop = 1'b1;
            end
        end
        avail = pending_pkt();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic add_beat(input bit s, input bit e, input int m, input bit er, input bit st);
        beat_t b;
        b.sop = s; b.eop = e; b.mod = 3'(m); b.err = er; b.stray = st;
        mac_q.push_back(b);
        avail = pending_pkt();
    endtask

    task automatic send_pkt(input int nbeats, input int m, input bit e, input bit nosop);
        for (int i = 0; i < nbeats; i++) begin
            add_beat((i == 0) && !nosop, i == nbeats - 1, (i == nbeats - 1) ? m : 0,
                     (i == nbeats - 1) ? e : 1'b0, 1'b0);
        end
    endtask

    task automatic expect_desc(input int len, input int st, input int len_s, input int st_s);
        exp_t e;
        e.len = len; e.st = st; e.len_s = len_s; e.st_s = st_s;
        sb_q.push_back(e);
        exp_pkt++;
        if (st != 0) exp_err++;
        if (st_s != 0) exp_err_s++;
    endtask

    task automatic settle();
        int guard = 0;
        while (mac_q.size() > 0 && guard < 400) begin
            tick();
            guard++;
        end
        check("mac_drained", mac_q.size(), 0);
        run(10);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_pkt_cnt_small"}, pkt_cnt_s, exp_pkt);
        check({tag, "_err_cnt_small"}, err_cnt_s, exp_err_s);
    endtask

    task automatic wait_ren(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (ren) seen = 1'b1;
        end
        check({tag, "_ren_rise"}, seen, 1);
    endtask

    initial begin
        bit found;
        vecs[0] = '{3, 5, 1'b0, 1'b0, 21, 0, 21, 0};
        vecs[1] = '{2, 0, 1'b0, 1'b0, 16, 0, 16, 0};
        vecs[2] = '{1, 3, 1'b0, 1'b1, 3, 2, 3, 2};
        vecs[3] = '{4, 0, 1'b1, 1'b1, 32, 3, 32, 3};
        vecs[4] = '{8, 7, 1'b0, 1'b0, 63, 0, 63, 0};
        vecs[5] = '{8, 0, 1'b0, 1'b0, 64, 0, 63, 4};
        vecs[6] = '{9, 0, 1'b0, 1'b0, 72, 0, 63, 4};
        vecs[7] = '{2, 1, 1'b1, 1'b0, 9, 1, 9, 1};

        rst_n = 1'b0; avail = 1'b0; val = 1'b0; sop = 1'b0; eop = 1'b0; mod = 3'd0;
        err = 1'b0; data = '0; desc_ready = 1'b0; ren_s = 1'b0; mac_stop = 1'b0;
        run(3);
        check("rst_ren", ren, 0);
        check("rst_desc_valid", desc_valid, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        run(2);

        // eop at cycle N must show desc_valid at N+1 into an empty FIFO.
        send_pkt(1, 0, 1'b1, 1'b0);
        expect_desc(8, 1, 8, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (val && eop) found = 1'b1;
        end
        check("lat_eop_seen", found, 1);
        check("lat_valid_at_eop", desc_valid, 0);
        tick();
        check("lat_valid_next", desc_valid, 1);
        desc_ready = 1'b1;
        settle();
        check_counts("lat");

        foreach (vecs[i]) begin
            send_pkt(vecs[i].nbeats, vecs[i].m, vecs[i].e, vecs[i].nosop);
            expect_desc(vecs[i].len, vecs[i].st, vecs[i].len_s, vecs[i].st_s);
            settle();
            check_counts($sformatf("vec%0d", i));
        end

        // sop on a non-first beat closes the running packet with the framing flag.
        add_beat(1'b1, 1'b0, 0, 1'b0, 1'b0);
        add_beat(1'b0, 1'b0, 0, 1'b0, 1'b0);
        add_beat(1'b1, 1'b0, 0, 1'b0, 1'b0);
        add_beat(1'b0, 1'b1, 2, 1'b0, 1'b0);
        expect_desc(16, 2, 16, 2);
        expect_desc(10, 0, 10, 0);
        settle();
        check_counts("resop");

        // A beat arriving in DRAIN is discarded and counted as an error.
        send_pkt(2, 4, 1'b0, 1'b0);
        add_beat(1'b0, 1'b0, 0, 1'b0, 1'b1);
        expect_desc(12, 0, 12, 0);
        exp_err++;
        exp_err_s++;
        settle();
        check_counts("drain_stray");

        // Full FIFO blocks the next packet until one descriptor is popped.
        desc_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_pkt(k, 0, 1'b0, 1'b0);
            expect_desc(8 * k, 0, (8 * k > 63) ? 63 : 8 * k, 0);
        end
        run(80);
        check("full_ren_blocked", ren, 0);
        check("full_ren_blocked_small", ren_small, 0);
        check("full_desc_valid", desc_valid, 1);
        check("full_pkt_cnt", pkt_cnt, exp_pkt - 1);
        desc_ready = 1'b1;
        tick();
        desc_ready = 1'b0;
        wait_ren("full_unblock");
        run(30);
        check("full_pkt_cnt_after", pkt_cnt, exp_pkt);
        desc_ready = 1'b1;
        settle();
        check("full_sb_empty", sb_q.size(), 0);

        // Reset mid-READ abandons the packet and clears everything.
        send_pkt(6, 0, 1'b0, 1'b0);
        wait_ren("rst_mid");
        run(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstmid_ren", ren, 0);
        check("rstmid_desc_valid", desc_valid, 0);
        exp_pkt = 0;
        exp_err = 0;
        exp_err_s = 0;
        run(5);
        check_counts("rstmid");
        add_beat(1'b0, 1'b0, 0, 1'b0, 1'b1);
        exp_err = 1;
        exp_err_s = 1;
        run(6);
        check_counts("idle_stray");
        check("idle_stray_no_desc", desc_valid, 0);
        check("final_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
